// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and coordinate widths for the sprite position array
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int X_W = 10;
    localparam int Y_W = 9;

endpackage

// File: rtl/sprite_axis_step.sv
// rtl/sprite_axis_step.sv - combinational next-coordinate unit for one axis (step, then clamp or wrap)
module sprite_axis_step #(
    parameter int W    = 10,
    parameter int MIN  = 26,
    parameter int MAX  = 614,
    parameter int STEP = 1,
    parameter int WRAP = 0
) (
    input  logic [W-1:0] cur,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] nxt
);

    localparam logic signed [W+1:0] MIN_S  = (W+2)'(MIN);
    localparam logic signed [W+1:0] MAX_S  = (W+2)'(MAX);
    localparam logic signed [W+1:0] STEP_S = (W+2)'(STEP);
    localparam logic [W-1:0]        MIN_W  = W'(MIN);
    localparam logic [W-1:0]        MAX_W  = W'(MAX);

    logic signed [W+1:0] raw;

    // Two guard bits keep a step below zero negative instead of wrapping to a large value.
    always_comb begin
        raw = signed'({2'b00, cur});
        if (dec && !inc) begin
            raw = raw - STEP_S;
        end else if (inc && !dec) begin
            raw = raw + STEP_S;
        end

        if (raw < MIN_S) begin
            nxt = (WRAP != 0) ? MAX_W : MIN_W;
        end else if (raw > MAX_S) begin
            nxt = (WRAP != 0) ? MIN_W : MAX_W;
        end else begin
            nxt = raw[W-1:0];
        end
    end

endmodule

// File: rtl/sprite_position_array.sv
// rtl/sprite_position_array.sv - N-sprite (x,y) position store with per-frame sweep update and teleport load
module sprite_position_array
    import sprite_pkg::*;
#(
    parameter int N_SPRITES     = 4,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PAD_X         = 10,
    parameter int PAD_Y         = 10,
    parameter int SPRITE_W      = 32,
    parameter int SPRITE_H      = 32,
    parameter int START_X       = 320,
    parameter int START_Y       = 454,
    parameter int STEP_X        = 1,
    parameter int STEP_Y        = 1,
    parameter int WRAP_X        = 0,
    parameter int WRAP_Y        = 0,
    localparam int ID_W         = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     global_reset_n,
    input  logic                     frame_tick,
    input  logic [N_SPRITES-1:0]     dir_left,
    input  logic [N_SPRITES-1:0]     dir_right,
    input  logic [N_SPRITES-1:0]     dir_up,
    input  logic [N_SPRITES-1:0]     dir_down,
    input  logic                     load_valid,
    input  logic [ID_W-1:0]          load_id,
    input  logic [X_W-1:0]           load_x,
    input  logic [Y_W-1:0]           load_y,
    output logic [N_SPRITES*X_W-1:0] pos_x,
    output logic [N_SPRITES*Y_W-1:0] pos_y,
    output logic                     busy,
    output logic                     update_done,
    output logic                     tick_dropped
);

    localparam int MIN_X = SPRITE_W / 2 + PAD_X;
    localparam int MAX_X = SCREEN_WIDTH - SPRITE_W / 2 - PAD_X;
    localparam int MIN_Y = SPRITE_H / 2 + PAD_Y;
    localparam int MAX_Y = SCREEN_HEIGHT - SPRITE_H / 2 - PAD_Y;

    localparam logic [X_W-1:0]  MIN_XV   = X_W'(MIN_X);
    localparam logic [X_W-1:0]  MAX_XV   = X_W'(MAX_X);
    localparam logic [Y_W-1:0]  MIN_YV   = Y_W'(MIN_Y);
    localparam logic [Y_W-1:0]  MAX_YV   = Y_W'(MAX_Y);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SPRITES - 1);
    localparam logic [ID_W:0]   N_ID     = (ID_W + 1)'(N_SPRITES);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        idx_q, idx_d;
    logic [N_SPRITES-1:0]   snap_left_q, snap_left_d;
    logic [N_SPRITES-1:0]   snap_right_q, snap_right_d;
    logic [N_SPRITES-1:0]   snap_up_q, snap_up_d;
    logic [N_SPRITES-1:0]   snap_down_q, snap_down_d;
    logic [X_W-1:0]         x_q [N_SPRITES];
    logic [X_W-1:0]         x_d [N_SPRITES];
    logic [Y_W-1:0]         y_q [N_SPRITES];
    logic [Y_W-1:0]         y_d [N_SPRITES];
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;

    logic [X_W-1:0]         step_x_nxt;
    logic [Y_W-1:0]         step_y_nxt;

    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v);
        if (v < MIN_XV) return MIN_XV;
        if (v > MAX_XV) return MAX_XV;
        return v;
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v);
        if (v < MIN_YV) return MIN_YV;
        if (v > MAX_YV) return MAX_YV;
        return v;
    endfunction

    // One step unit per axis, time-shared across sprites by the sweep index.
    sprite_axis_step #(
        .W(X_W), .MIN(MIN_X), .MAX(MAX_X), .STEP(STEP_X), .WRAP(WRAP_X)
    ) u_step_x (
        .cur (x_q[idx_q]),
        .dec (snap_left_q[idx_q]),
        .inc (snap_right_q[idx_q]),
        .nxt (step_x_nxt)
    );

    sprite_axis_step #(
        .W(Y_W), .MIN(MIN_Y), .MAX(MAX_Y), .STEP(STEP_Y), .WRAP(WRAP_Y)
    ) u_step_y (
        .cur (y_q[idx_q]),
        .dec (snap_up_q[idx_q]),
        .inc (snap_down_q[idx_q]),
        .nxt (step_y_nxt)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_left_d  = snap_left_q;
        snap_right_d = snap_right_q;
        snap_up_d    = snap_up_q;
        snap_down_d  = snap_down_q;
        x_d          = x_q;
        y_d          = y_q;
        drop_d       = frame_tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    snap_left_d  = dir_left;
                    snap_right_d = dir_right;
                    snap_up_d    = dir_up;
                    snap_down_d  = dir_down;
                    idx_d        = '0;
                    state_d      = UPDATE;
                end
            end
            UPDATE: begin
                x_d[idx_q] = step_x_nxt;
                y_d[idx_q] = step_y_nxt;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Applied after the sweep write so a load to the same sprite overrides the step.
        if (load_valid && ({1'b0, load_id} < N_ID)) begin
            x_d[load_id] = clamp_x(load_x);
            y_d[load_id] = clamp_y(load_y);
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_left_q  <= '0;
            snap_right_q <= '0;
            snap_up_q    <= '0;
            snap_down_q  <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                x_q[i] <= X_W'(START_X);
                y_q[i] <= Y_W'(START_Y);
            end
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_left_q  <= snap_left_d;
            snap_right_q <= snap_right_d;
            snap_up_q    <= snap_up_d;
            snap_down_q  <= snap_down_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_pack
        assign pos_x[g*X_W +: X_W] = x_q[g];
        assign pos_y[g*Y_W +: Y_W] = y_q[g];
    end

    assign busy         = busy_q;
    assign update_done  = done_q;
    assign tick_dropped = drop_q;

endmodule

// File: tb/tb_sprite_position_array.sv
// tb/tb_sprite_position_array.sv - self-checking bench for sprite_position_array (clamp and wrap-x instances)
module tb_sprite_position_array;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic [N-1:0] dir_left = '0, dir_right = '0, dir_up = '0, dir_down = '0;
    logic         load_valid = 1'b0;
    logic [1:0]   load_id = '0;
    logic [9:0]   load_x = '0;
    logic [8:0]   load_y = '0;

    logic [N*10-1:0] px [2];
    logic [N*9-1:0]  py [2];
    logic [1:0]      busy_o, done_o, drop_o;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    sprite_position_array u_clamp (
        .CLOCK_50(clk), .global_reset_n(rst_n), .frame_tick(frame_tick),
        .dir_left(dir_left), .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down),
        .load_valid(load_valid), .load_id(load_id), .load_x(load_x), .load_y(load_y),
        .pos_x(px[0]), .pos_y(py[0]), .busy(busy_o[0]), .update_done(done_o[0]),
        .tick_dropped(drop_o[0])
    );

    sprite_position_array #(.WRAP_X(1)) u_wrap (
        .CLOCK_50(clk), .global_reset_n(rst_n), .frame_tick(frame_tick),
        .dir_left(dir_left), .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down),
        .load_valid(load_valid), .load_id(load_id), .load_x(load_x), .load_y(load_y),
        .pos_x(px[1]), .pos_y(py[1]), .busy(busy_o[1]), .update_done(done_o[1]),
        .tick_dropped(drop_o[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int xof(input int w, input int i);
        return int'(px[w][i*10 +: 10]);
    endfunction

    function automatic int yof(input int w, input int i);
        return int'(py[w][i*9 +: 9]);
    endfunction

    // Reference model: phase 0 idle, 1..N writing sprite phase-1, N+1 done.
    int mx [2][N];
    int my [2][N];
    int phase;
    bit e_busy, e_done, e_drop;
    bit [N-1:0] sl, sr, su, sd;

    function automatic int step_axis(input int v, input bit dec, input bit inc,
                                     input int mn, input int mxv, input bit wrap);
        int r;
        r = v;
        if (dec && !inc) r = v - 1;
        else if (inc && !dec) r = v + 1;
        if (r < mn) r = wrap ? mxv : mn;
        else if (r > mxv) r = wrap ? mn : mxv;
        return r;
    endfunction

    function automatic int clampv(input int v, input int mn, input int mxv);
        return (v < mn) ? mn : ((v > mxv) ? mxv : v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < N; i++) begin
                    mx[w][i] = 320;
                    my[w][i] = 454;
                end
            phase  = 0;
            e_busy = 0;
            e_done = 0;
            e_drop = 0;
        end else begin
            e_drop = frame_tick && (phase != 0);
            if (phase == 0) begin
                if (frame_tick) begin
                    sl = dir_left; sr = dir_right; su = dir_up; sd = dir_down;
                    phase = 1;
                end
            end else if (phase <= N) begin
                for (int w = 0; w < 2; w++) begin
                    mx[w][phase-1] = step_axis(mx[w][phase-1], sl[phase-1], sr[phase-1], 26, 614, w == 1);
                    my[w][phase-1] = step_axis(my[w][phase-1], su[phase-1], sd[phase-1], 26, 454, 1'b0);
                end
                phase++;
            end else begin
                phase = 0;
            end
            if (load_valid && int'(load_id) < N) begin
                for (int w = 0; w < 2; w++) begin
                    mx[w][load_id] = clampv(int'(load_x), 26, 614);
                    my[w][load_id] = clampv(int'(load_y), 26, 454);
                end
            end
            e_busy = (phase != 0);
            e_done = (phase == N + 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int w = 0; w < 2; w++) begin
                check($sformatf("m%0d_busy", w), int'(busy_o[w]), int'(e_busy));
                check($sformatf("m%0d_done", w), int'(done_o[w]), int'(e_done));
                check($sformatf("m%0d_drop", w), int'(drop_o[w]), int'(e_drop));
                for (int i = 0; i < N; i++) begin
                    check($sformatf("m%0d_x%0d", w, i), xof(w, i), mx[w][i]);
                    check($sformatf("m%0d_y%0d", w, i), yof(w, i), my[w][i]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic load(input int id, input int x, input int y);
        load_valid = 1'b1;
        load_id = 2'(id);
        load_x = 10'(x);
        load_y = 9'(y);
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o[0] && n < 20) begin
            cyc();
            n++;
        end
        check("idle_timeout", int'(busy_o[0]), 0);
        cyc();
    endtask

    initial begin
        int cnt;

        // 1: reset
        rst_n = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_x", xof(0, i), 320);
            check("rst_y", yof(0, i), 454);
        end
        check("rst_busy", int'(busy_o[0]), 0);
        check("rst_done", int'(done_o[0]), 0);
        rst_n = 1'b1;
        cyc();
        chk_en = 1;

        // 2: sweep; dir bits scrambled mid-sweep must not matter
        dir_right = 4'b0001;
        dir_up    = 4'b0100;
        tick();
        dir_right = 4'b1111;
        dir_up    = 4'b0000;
        dir_left  = 4'b1111;
        cyc();
        @(negedge clk);
        check("sw_x0_k1", xof(0, 0), 321);
        check("sw_busy_k1", int'(busy_o[0]), 1);
        cyc();
        cyc();
        @(negedge clk);
        check("sw_y2_k3", yof(0, 2), 453);
        check("sw_x1", xof(0, 1), 320);
        check("sw_y1", yof(0, 1), 454);
        cyc();
        @(negedge clk);
        check("sw_done_k4", int'(done_o[0]), 1);
        check("sw_busy_k4", int'(busy_o[0]), 1);
        check("sw_x3", xof(0, 3), 320);
        check("sw_y3", yof(0, 3), 454);
        cyc();
        @(negedge clk);
        check("sw_busy_k5", int'(busy_o[0]), 0);
        check("sw_done_k5", int'(done_o[0]), 0);
        dir_right = '0;
        dir_left  = '0;
        cyc();

        // 3: clamp at lower bounds, then out-of-range load
        load(1, 26, 26);
        dir_left = 4'b0010;
        dir_up   = 4'b0010;
        tick();
        dir_left = '0;
        dir_up   = '0;
        wait_idle();
        @(negedge clk);
        check("cl_x1", xof(0, 1), 26);
        check("cl_y1", yof(0, 1), 26);
        check("wr_x1", xof(1, 1), 614);
        load(1, 700, 500);
        @(negedge clk);
        check("cl_ld_x", xof(0, 1), 614);
        check("cl_ld_y", yof(0, 1), 454);
        check("wr_ld_x", xof(1, 1), 614);

        // 4: wrap vs clamp on x
        load(0, 26, 454);
        dir_left = 4'b0001;
        tick();
        dir_left = '0;
        wait_idle();
        @(negedge clk);
        check("wr_left", xof(1, 0), 614);
        check("cl_left", xof(0, 0), 26);
        load(0, 614, 454);
        dir_right = 4'b0001;
        tick();
        dir_right = '0;
        wait_idle();
        @(negedge clk);
        check("wr_right", xof(1, 0), 26);
        check("cl_right", xof(0, 0), 614);

        // 5: load collides with sweep write of sprite 2; overrun tick dropped
        dir_down = 4'b0100;
        tick();
        dir_down = '0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        @(negedge clk);
        check("ov_drop", int'(drop_o[0]), 1);
        load(2, 100, 100);
        @(negedge clk);
        check("co_x2", xof(0, 2), 100);
        check("co_y2", yof(0, 2), 100);
        cnt = 0;
        repeat (8) begin
            cyc();
            @(negedge clk);
            if (done_o[0]) cnt++;
        end
        check("ov_done_cnt", cnt, 1);
        check("ov_idle", int'(busy_o[0]), 0);

        // 6: reset mid-sweep
        dir_right = 4'b1111;
        tick();
        dir_right = '0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check("mr_x0", xof(0, 0), 320);
        check("mr_y2", yof(0, 2), 454);
        check("mr_x2", xof(0, 2), 320);
        check("mr_busy", int'(busy_o[0]), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            cyc();
            @(negedge clk);
            if (done_o[0]) cnt++;
        end
        check("mr_no_done", cnt, 0);
        check("mr_busy_after", int'(busy_o[0]), 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
